z80_io_uart: RTL and testbench



---
 rtl/z80_io_uart_if.sv | 17 +
 rtl/z80_io_uart.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_z80_io_uart.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_io_uart_if.sv
// Z80 I/O bus bundle between the CPU glue (master) and the UART (slave).
interface z80_io_uart_if;
   logic       CPUCLK0;
   logic [7:0] A;
   logic [7:0] D_in;
   logic       nIORQ;
   logic       nRD;
   logic       nWR;
   logic       nM1;
   logic [7:0] d_out;
   logic       d_oe;

   modport master (output CPUCLK0, A, D_in, nIORQ, nRD, nWR, nM1,
                   input  d_out, d_oe);
   modport slave  (input  CPUCLK0, A, D_in, nIORQ, nRD, nWR, nM1,
                   output d_out, d_oe);
endinterface

// File: rtl/z80_io_uart.sv
// Z80 I/O-mapped 8N1 UART with TX/RX FIFOs and a runtime 16x-oversample baud divisor.
// Optional interrupt output is built when UART_IRQ_EN is defined; DIV_W must lie in 9..16.

module z80_io_uart_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         CLK50MHz,
   input  logic         nRESET,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [0:DEPTH-1];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push_ok;
   logic          pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i & ~empty_o;
   // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
   assign push_ok = push_i & (~full_o | pop_i);
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge CLK50MHz) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push_ok & ~pop_ok) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (pop_ok & ~push_ok) begin
            count_q <= count_q - (AW+1)'(1);
         end
      end
   end
endmodule

module z80_io_uart #(
   parameter logic [7:0] BASE_ADDR  = 8'h10,
   parameter int         FIFO_DEPTH = 16,
   parameter int         DIV_W      = 16,
   parameter int         DIV_RESET  = 27
) (
   input  logic         CLK50MHz,
   input  logic         nRESET,
   z80_io_uart_if.slave bus,
   output logic         tx,
   input  logic         rx,
   output logic         irq
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   logic             hit;
   logic             rd_act;
   logic             wr_fire;
   logic             wr_tx;
   logic             wr_stat;
   logic             wr_div_lo;
   logic             wr_div_hi;
   logic             rd_q;
   logic [1:0]       rd_off_q;
   logic             wr_done_q;
   logic             rx_pop_req;

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] tick_cnt_q;
   logic [DIV_W-1:0] tick_reload;
   logic             tick;
   logic [7:0]       div_hi_rd;

   logic [7:0]       tx_fifo_dout;
   logic             tx_empty;
   logic             tx_full;
   logic             tx_pop;
   uart_state_t      tx_state_q, tx_state_d;
   logic [3:0]       tx_tcnt_q, tx_tcnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_q, tx_d;

   logic [7:0]       rx_fifo_dout;
   logic             rx_empty;
   logic             rx_full;
   logic             rx_s1_q;
   logic             rx_s2_q;
   logic             rx_prev_q;
   uart_state_t      rx_state_q, rx_state_d;
   logic [3:0]       rx_tcnt_q, rx_tcnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_store;
   logic             rx_frame_err;

   logic             ovr_q;
   logic             fe_q;
   logic [1:0]       ien;
   logic             txidle;
   logic             txnf;
   logic             rxne;
   logic [7:0]       status;

   assign hit       = ~bus.nIORQ & bus.nM1 & (bus.A[7:2] == BASE_ADDR[7:2]);
   assign rd_act    = hit & ~bus.nRD;
   assign bus.d_oe  = rd_act;
   assign wr_fire   = bus.CPUCLK0 & hit & ~bus.nWR & ~wr_done_q;
   assign wr_tx     = wr_fire & (bus.A[1:0] == 2'd0);
   assign wr_stat   = wr_fire & (bus.A[1:0] == 2'd1);
   assign wr_div_lo = wr_fire & (bus.A[1:0] == 2'd2);
   assign wr_div_hi = wr_fire & (bus.A[1:0] == 2'd3);
   // The pop is deferred to the end of the read so a long read cycle pops once.
   assign rx_pop_req = rd_q & ~rd_act & (rd_off_q == 2'd0);

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         rd_q      <= 1'b0;
         rd_off_q  <= 2'd0;
         wr_done_q <= 1'b0;
      end else begin
         rd_q <= rd_act;
         if (rd_act) begin
            rd_off_q <= bus.A[1:0];
         end
         wr_done_q <= bus.nIORQ ? 1'b0 : (wr_done_q | wr_fire);
      end
   end

   assign tick_reload = (div_q == '0) ? '0 : div_q - DIV_W'(1);
   assign tick        = (tick_cnt_q == '0);

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         div_q      <= DIV_W'(DIV_RESET);
         tick_cnt_q <= '0;
      end else begin
         if (wr_div_lo) begin
            div_q[7:0] <= bus.D_in;
         end
         if (wr_div_hi) begin
            div_q[DIV_W-1:8] <= bus.D_in[DIV_W-9:0];
         end
         tick_cnt_q <= tick ? tick_reload : tick_cnt_q - DIV_W'(1);
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_div_hi
      if (gi + 8 < DIV_W) begin : g_bit
         assign div_hi_rd[gi] = div_q[gi+8];
      end else begin : g_zero
         assign div_hi_rd[gi] = 1'b0;
      end
   end

   z80_io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
      .CLK50MHz (CLK50MHz),
      .nRESET   (nRESET),
      .push_i   (wr_tx),
      .din_i    (bus.D_in),
      .pop_i    (tx_pop),
      .dout_o   (tx_fifo_dout),
      .empty_o  (tx_empty),
      .full_o   (tx_full)
   );

   z80_io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
      .CLK50MHz (CLK50MHz),
      .nRESET   (nRESET),
      .push_i   (rx_store),
      .din_i    (rx_shift_q),
      .pop_i    (rx_pop_req),
      .dout_o   (rx_fifo_dout),
      .empty_o  (rx_empty),
      .full_o   (rx_full)
   );

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         tx_state_q <= S_IDLE;
         tx_tcnt_q  <= 4'd0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'd0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tcnt_d  = tx_tcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            if (tick & ~tx_empty) begin
               tx_state_d = S_START;
               tx_pop     = 1'b1;
               tx_shift_d = tx_fifo_dout;
               tx_tcnt_d  = 4'd0;
            end
         end
         S_START: begin
            if (tick) begin
               tx_tcnt_d = tx_tcnt_q + 4'd1;
               if (tx_tcnt_q == 4'd15) begin
                  tx_state_d = S_DATA;
                  tx_bit_d   = 3'd0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               tx_tcnt_d = tx_tcnt_q + 4'd1;
               if (tx_tcnt_q == 4'd15) begin
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_bit_d   = tx_bit_q + 3'd1;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_d = S_STOP;
                  end
               end
            end
         end
         default: begin
            if (tick) begin
               tx_tcnt_d = tx_tcnt_q + 4'd1;
               if (tx_tcnt_q == 4'd15) begin
                  tx_state_d = S_IDLE;
               end
            end
         end
      endcase
      tx_d = 1'b1;
      if (tx_state_d == S_START) begin
         tx_d = 1'b0;
      end else if (tx_state_d == S_DATA) begin
         tx_d = tx_shift_d[0];
      end
   end

   assign tx = tx_q;

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_tcnt_q  <= 4'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_tcnt_d    = rx_tcnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_store     = 1'b0;
      rx_frame_err = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q & ~rx_s2_q) begin
               rx_state_d = S_START;
               rx_tcnt_d  = 4'd0;
            end
         end
         S_START: begin
            // Half-bit re-check of the start bit filters short glitches.
            if (tick) begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
               if (rx_tcnt_q == 4'd7) begin
                  rx_tcnt_d  = 4'd0;
                  rx_bit_d   = 3'd0;
                  rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
               if (rx_tcnt_q == 4'd15) begin
                  rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                  rx_bit_d   = rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) begin
                     rx_state_d = S_STOP;
                  end
               end
            end
         end
         default: begin
            if (tick) begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
               if (rx_tcnt_q == 4'd15) begin
                  rx_store     = 1'b1;
                  rx_frame_err = ~rx_s2_q;
                  rx_state_d   = S_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         ovr_q <= 1'b0;
         fe_q  <= 1'b0;
      end else begin
         if (wr_stat & bus.D_in[2]) begin
            ovr_q <= 1'b0;
         end
         if (rx_store & rx_full & ~rx_pop_req) begin
            ovr_q <= 1'b1;
         end
         if (wr_stat & bus.D_in[3]) begin
            fe_q <= 1'b0;
         end
         if (rx_store & rx_frame_err) begin
            fe_q <= 1'b1;
         end
      end
   end

   assign txidle = (tx_state_q == S_IDLE) & tx_empty;
   assign txnf   = ~tx_full;
   assign rxne   = ~rx_empty;

`ifdef UART_IRQ_EN
   logic [1:0] ien_q;
   logic       irq_q;

   always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
         ien_q <= 2'b00;
         irq_q <= 1'b0;
      end else begin
         if (wr_stat) begin
            ien_q <= bus.D_in[6:5];
         end
         irq_q <= (ien_q[0] & rxne) | (ien_q[1] & txnf);
      end
   end

   assign ien = ien_q;
   assign irq = irq_q;
`else
   assign ien = 2'b00;
   assign irq = 1'b0;
`endif

   assign status = {1'b0, ien, txidle, fe_q, ovr_q, txnf, rxne};

   always_comb begin
      case (bus.A[1:0])
         2'd0:    bus.d_out = rxne ? rx_fifo_dout : 8'hFF;
         2'd1:    bus.d_out = status;
         2'd2:    bus.d_out = div_q[7:0];
         default: bus.d_out = div_hi_rd;
      endcase
   end
endmodule

// File: tb/tb_z80_io_uart.sv
// Directed/randomised bench for z80_io_uart: bus access, TX waveform, loopback RX,
// overrun, glitch filter, framing error and (optionally) the interrupt.
module tb_z80_io_uart;
   localparam logic [7:0] BASE  = 8'h10;
   localparam int         DEPTH = 16;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic loop = 1'b0;
   logic rx_drv = 1'b1;
   logic tx_w;
   logic rx_w;
   logic irq_w;
   int   total = 0;
   int   bad = 0;
   int   cpu_div = 0;

   logic [7:0] rxq[$];
   bit         ovr_m = 1'b0;

   z80_io_uart_if bus_if ();

   z80_io_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(27)) dut (
      .CLK50MHz (clk),
      .nRESET   (nreset),
      .bus      (bus_if),
      .tx       (tx_w),
      .rx       (rx_w),
      .irq      (irq_w)
   );

   assign rx_w = loop ? tx_w : rx_drv;

   always #10 clk = ~clk;

   always @(negedge clk) begin
      cpu_div = (cpu_div + 1) % 4;
      bus_if.CPUCLK0 = (cpu_div == 0);
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic io_write(input logic [1:0] port, input logic [7:0] data);
      @(negedge clk);
      bus_if.A = BASE | {6'd0, port};
      bus_if.D_in = data;
      bus_if.nM1 = 1'b1;
      bus_if.nIORQ = 1'b0;
      bus_if.nWR = 1'b0;
      repeat (10) @(negedge clk);
      bus_if.nWR = 1'b1;
      bus_if.nIORQ = 1'b1;
      @(negedge clk);
      $display("wr port=%0d data=%02h", port, data);
   endtask

   task automatic io_read(input logic [1:0] port, input int hold, input bit quiet,
                          output logic [7:0] data);
      logic oe;
      @(negedge clk);
      bus_if.A = BASE | {6'd0, port};
      bus_if.nM1 = 1'b1;
      bus_if.nIORQ = 1'b0;
      bus_if.nRD = 1'b0;
      @(negedge clk);
      data = bus_if.d_out;
      oe = bus_if.d_oe;
      repeat (hold) @(negedge clk);
      bus_if.nRD = 1'b1;
      bus_if.nIORQ = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (!quiet) begin
         $display("rd port=%0d hold=%0d data=%02h", port, hold, data);
         check("d_oe_read", {31'd0, oe}, 32'd1);
      end
   endtask

   task automatic wait_status(input logic [7:0] mask, input logic [7:0] val, input int budget,
                              input string tag);
      logic [7:0] s;
      bit ok;
      ok = 1'b0;
      s = 8'h00;
      for (int i = 0; i < budget; i++) begin
         io_read(2'd1, 0, 1'b1, s);
         if ((s & mask) == val) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic rd_check(input logic [1:0] port, input int hold, input string tag,
                           input logic [7:0] exp);
      logic [7:0] d;
      io_read(port, hold, 1'b0, d);
      check(tag, {24'd0, d}, {24'd0, exp});
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = bits[i];
         repeat (64) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] d;
      logic [7:0] exp_b;
      int         n;
      bit         seen;
      bit         any_irq;

      bus_if.A = 8'h00;
      bus_if.D_in = 8'h00;
      bus_if.nIORQ = 1'b1;
      bus_if.nRD = 1'b1;
      bus_if.nWR = 1'b1;
      bus_if.nM1 = 1'b1;
      repeat (5) @(negedge clk);
      nreset = 1'b1;
      repeat (2) @(negedge clk);

      check("reset_tx", {31'd0, tx_w}, 32'd1);
      check("reset_irq", {31'd0, irq_w}, 32'd0);
      check("idle_d_oe", {31'd0, bus_if.d_oe}, 32'd0);
      rd_check(2'd1, 0, "reset_status", 8'h12);
      rd_check(2'd0, 0, "reset_rx_empty", 8'hFF);
      rd_check(2'd2, 0, "reset_div_lo", 8'd27);
      rd_check(2'd3, 0, "reset_div_hi", 8'h00);

      // Decode boundaries: foreign address and interrupt-acknowledge cycles.
      @(negedge clk);
      bus_if.A = 8'h20;
      bus_if.nIORQ = 1'b0;
      bus_if.nRD = 1'b0;
      @(negedge clk);
      check("other_addr_d_oe", {31'd0, bus_if.d_oe}, 32'd0);
      bus_if.A = BASE | 8'h02;
      bus_if.nM1 = 1'b0;
      bus_if.nRD = 1'b1;
      bus_if.D_in = 8'h77;
      bus_if.nWR = 1'b0;
      @(negedge clk);
      check("inta_d_oe", {31'd0, bus_if.d_oe}, 32'd0);
      repeat (8) @(negedge clk);
      bus_if.nWR = 1'b1;
      bus_if.nIORQ = 1'b1;
      bus_if.nM1 = 1'b1;
      rd_check(2'd2, 0, "inta_no_write", 8'd27);

      io_write(2'd2, 8'h04);
      io_write(2'd3, 8'h00);
      rd_check(2'd2, 0, "div_lo_4", 8'h04);

      // TX waveform of 8'hA5: start 64 clk, LSB first at 64 clk per bit, stop high.
      exp_b = 8'hA5;
      fork
         io_write(2'd0, exp_b);
         begin
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (tx_w === 1'b0) begin
                  seen = 1'b1;
                  break;
               end
            end
            check("tx_start_seen", {31'd0, seen}, 32'd1);
            n = 1;
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (tx_w !== 1'b0) break;
               n++;
            end
            check("tx_start_len", n, 64);
            repeat (32) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               check($sformatf("tx_bit%0d", i), {31'd0, tx_w}, {31'd0, exp_b[i]});
               repeat (64) @(negedge clk);
            end
            check("tx_stop", {31'd0, tx_w}, 32'd1);
         end
      join
      wait_status(8'h10, 8'h10, 300, "tx_idle_return");
      rd_check(2'd1, 0, "status_after_tx", 8'h12);

      loop = 1'b1;
      io_write(2'd0, 8'h3C);
      wait_status(8'h01, 8'h01, 400, "loop_rxne");
      wait_status(8'h10, 8'h10, 300, "loop_txidle");
      rd_check(2'd1, 0, "loop_status_rxne", 8'h13);
      rd_check(2'd0, 0, "loop_data_3c", 8'h3C);
      rd_check(2'd1, 0, "loop_status_empty", 8'h12);

      // Random burst queued in the TX FIFO, read back with random read-cycle lengths.
      for (int k = 0; k < 5; k++) begin
         b = 8'($urandom);
         rxq.push_back(b);
         io_write(2'd0, b);
      end
      wait_status(8'h10, 8'h10, 1500, "burst_txidle");
      for (int k = 0; k < 5; k++) begin
         exp_b = rxq.pop_front();
         rd_check(2'd0, int'($urandom_range(0, 40)), $sformatf("burst_data%0d", k), exp_b);
      end
      rd_check(2'd1, 0, "burst_status_empty", 8'h12);

      // Overrun: DEPTH+2 frames with no reads.
      for (int k = 0; k < DEPTH + 2; k++) begin
         b = 8'($urandom);
         if (rxq.size() < DEPTH) rxq.push_back(b);
         else ovr_m = 1'b1;
         io_write(2'd0, b);
         wait_status(8'h10, 8'h10, 400, "ovr_txidle");
      end
      rd_check(2'd1, 0, "ovr_status_set", 8'h13 | {5'd0, ovr_m, 2'b00});
      for (int k = 0; k < DEPTH; k++) begin
         exp_b = rxq.pop_front();
         rd_check(2'd0, 0, $sformatf("ovr_data%0d", k), exp_b);
      end
      rd_check(2'd0, 0, "ovr_drained", 8'hFF);
      io_write(2'd1, 8'h04);
      ovr_m = 1'b0;
      rd_check(2'd1, 0, "ovr_cleared", 8'h12);

      loop = 1'b0;
      rx_drv = 1'b0;
      repeat (12) @(negedge clk);
      rx_drv = 1'b1;
      repeat (300) @(negedge clk);
      rd_check(2'd1, 0, "glitch_no_store", 8'h12);

      b = 8'($urandom);
      drive_frame(b, 1'b0);
      repeat (100) @(negedge clk);
      rd_check(2'd1, 0, "fe_status_set", 8'h1B);
      rd_check(2'd0, 0, "fe_data", b);
      rd_check(2'd1, 0, "fe_status_popped", 8'h1A);
      io_write(2'd1, 8'h08);
      rd_check(2'd1, 0, "fe_cleared", 8'h12);

      b = 8'($urandom);
      drive_frame(b, 1'b1);
      repeat (100) @(negedge clk);
      rd_check(2'd0, 0, "ext_frame_data", b);

      loop = 1'b1;
`ifdef UART_IRQ_EN
      io_write(2'd1, 8'h20);
      rd_check(2'd1, 0, "irq_ien_status", 8'h32);
      check("irq_low_before", {31'd0, irq_w}, 32'd0);
      b = 8'($urandom);
      io_write(2'd0, b);
      seen = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (irq_w === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("irq_rise", {31'd0, seen}, 32'd1);
      io_read(2'd1, 0, 1'b0, d);
      check("irq_status_rxne", {24'd0, d & 8'h61}, 32'h21);
      rd_check(2'd0, 0, "irq_data", b);
      check("irq_low_after_pop", {31'd0, irq_w}, 32'd0);
      io_write(2'd1, 8'h00);
`else
      io_write(2'd1, 8'h60);
      rd_check(2'd1, 0, "no_ien_status", 8'h12);
      b = 8'($urandom);
      any_irq = 1'b0;
      fork
         io_write(2'd0, b);
         begin
            for (int i = 0; i < 800; i++) begin
               @(negedge clk);
               if (irq_w !== 1'b0) any_irq = 1'b1;
            end
         end
      join
      check("irq_tied_low", {31'd0, any_irq}, 32'd0);
      wait_status(8'h10, 8'h10, 300, "no_irq_txidle");
      rd_check(2'd0, 0, "no_irq_data", b);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
